// File: rtl/camera_capture_if.sv
// Camera-side sample bus and frame-buffer-side pixel/status bus for camera_capture.
// slave is the capture block's view; master is the driver/observer view.
interface camera_capture_if #(
  parameter int unsigned ADDR_WIDTH = 19
);
  logic                  vsync;
  logic                  href;
  logic [7:0]            d;
  logic [15:0]           pixel_data;
  logic                  pixel_valid;
  logic [ADDR_WIDTH-1:0] pixel_addr;
  logic                  frame_done;
  logic                  line_error;
  logic                  overflow;

  modport master (
    output vsync, href, d,
    input  pixel_data, pixel_valid, pixel_addr, frame_done, line_error, overflow
  );

  modport slave (
    input  vsync, href, d,
    output pixel_data, pixel_valid, pixel_addr, frame_done, line_error, overflow
  );
endinterface

// File: rtl/camera_capture.sv
// OV7670 parallel capture: pairs vsync/href-qualified bytes into RGB565 pixels with a
// linear frame-buffer address, plus end-of-frame pulse and sticky line/overflow status.
module camera_capture #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned ADDR_WIDTH = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  camera_capture_if.slave   cam
);

  localparam int unsigned PixW     = $clog2(H_ACTIVE + 2);
  localparam int unsigned LineW    = $clog2(V_ACTIVE + 2);
  // One extra bit so the counter can sit at H_ACTIVE*V_ACTIVE even when that equals 2^ADDR_WIDTH.
  localparam int unsigned AddrCntW = ADDR_WIDTH + 1;

  localparam logic [PixW-1:0]     HAct    = PixW'(H_ACTIVE);
  localparam logic [PixW-1:0]     PixSat  = PixW'(H_ACTIVE + 1);
  localparam logic [LineW-1:0]    VAct    = LineW'(V_ACTIVE);
  localparam logic [LineW-1:0]    LineSat = LineW'(V_ACTIVE + 1);
  localparam logic [AddrCntW-1:0] Total   = AddrCntW'(H_ACTIVE * V_ACTIVE);

  typedef enum logic [1:0] {StIdle, StWaitVs, StWaitFrame, StCapture} state_e;

  state_e state_q, state_d;

  logic       vs_r, vs_rr, hr_r, hr_rr;
  logic [7:0] d_r;

  logic                  phase_q, phase_d;
  logic [7:0]            hi_q, hi_d;
  logic [AddrCntW-1:0]   addr_q, addr_d;
  logic [PixW-1:0]       line_pix_q, line_pix_d;
  logic [LineW-1:0]      line_cnt_q, line_cnt_d;
  logic [LineW-1:0]      line_cnt_eff;

  logic                  pend_valid_q, pend_valid_d;
  logic [15:0]           pend_data_q, pend_data_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;

  logic [15:0]           pixel_data_q, pixel_data_d;
  logic                  pixel_valid_q, pixel_valid_d;
  logic [ADDR_WIDTH-1:0] pixel_addr_q, pixel_addr_d;
  logic                  frame_done_q, frame_done_d;
  logic                  line_error_q, line_error_d;
  logic                  overflow_q, overflow_d;

  logic hr_fall, vs_fall, vs_rise;

  assign hr_fall = hr_rr & ~hr_r;
  assign vs_fall = vs_rr & ~vs_r;
  assign vs_rise = vs_r & ~vs_rr;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    addr_d       = addr_q;
    line_pix_d   = line_pix_q;
    line_cnt_d   = line_cnt_q;
    line_cnt_eff = line_cnt_q;
    pend_valid_d = 1'b0;
    pend_data_d  = pend_data_q;
    pend_addr_d  = pend_addr_q;
    frame_done_d = 1'b0;
    line_error_d = line_error_q;
    overflow_d   = overflow_q;

    // Output stage: a pixel formed last edge is suppressed as soon as start=0 is sampled.
    pixel_valid_d = pend_valid_q & start;
    pixel_data_d  = pend_valid_q ? pend_data_q : pixel_data_q;
    pixel_addr_d  = pend_valid_q ? pend_addr_q : pixel_addr_q;

    if (!start) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StWaitVs;

        StWaitVs: if (vs_r) state_d = StWaitFrame;

        StWaitFrame: begin
          if (vs_fall) begin
            state_d      = StCapture;
            addr_d       = '0;
            line_cnt_d   = '0;
            line_pix_d   = '0;
            phase_d      = 1'b0;
            line_error_d = 1'b0;
            overflow_d   = 1'b0;
          end
        end

        StCapture: begin
          if (hr_r) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
              hi_d = d_r;
            end else begin
              if (line_pix_q != PixSat) line_pix_d = line_pix_q + PixW'(1);
              if (addr_q == Total) begin
                overflow_d = 1'b1;
              end else begin
                pend_valid_d = 1'b1;
                pend_data_d  = {hi_q, d_r};
                pend_addr_d  = addr_q[ADDR_WIDTH-1:0];
                addr_d       = addr_q + AddrCntW'(1);
              end
            end
          end

          // Line end is folded in before the frame-end line-count check.
          if (hr_fall) begin
            if (line_pix_q != HAct || phase_q) line_error_d = 1'b1;
            if (line_cnt_q != LineSat) line_cnt_eff = line_cnt_q + LineW'(1);
            line_cnt_d = line_cnt_eff;
            phase_d    = 1'b0;
            line_pix_d = '0;
          end

          if (vs_rise) begin
            frame_done_d = 1'b1;
            if (line_cnt_eff != VAct) line_error_d = 1'b1;
            state_d = StWaitFrame;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      vs_r          <= 1'b0;
      vs_rr         <= 1'b0;
      hr_r          <= 1'b0;
      hr_rr         <= 1'b0;
      d_r           <= '0;
      phase_q       <= 1'b0;
      hi_q          <= '0;
      addr_q        <= '0;
      line_pix_q    <= '0;
      line_cnt_q    <= '0;
      pend_valid_q  <= 1'b0;
      pend_data_q   <= '0;
      pend_addr_q   <= '0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      pixel_addr_q  <= '0;
      frame_done_q  <= 1'b0;
      line_error_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_r          <= cam.vsync;
      vs_rr         <= vs_r;
      hr_r          <= cam.href;
      hr_rr         <= hr_r;
      d_r           <= cam.d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      addr_q        <= addr_d;
      line_pix_q    <= line_pix_d;
      line_cnt_q    <= line_cnt_d;
      pend_valid_q  <= pend_valid_d;
      pend_data_q   <= pend_data_d;
      pend_addr_q   <= pend_addr_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_addr_q  <= pixel_addr_d;
      frame_done_q  <= frame_done_d;
      line_error_q  <= line_error_d;
      overflow_q    <= overflow_d;
    end
  end

  assign cam.pixel_data  = pixel_data_q;
  assign cam.pixel_valid = pixel_valid_q;
  assign cam.pixel_addr  = pixel_addr_q;
  assign cam.frame_done  = frame_done_q;
  assign cam.line_error  = line_error_q;
  assign cam.overflow    = overflow_q;

endmodule
